// File: rtl/ram_ahb_arbiter_if.sv
// Manager-side AHB-Lite bus bundle for the two-manager RAM arbiter.
// master: the bus manager (core or DMA); slave: the arbiter port facing it.
interface ram_ahb_arbiter_if #(
    parameter int unsigned PA_BITS = 32,
    parameter int unsigned XLEN    = 32
);
    logic [1:0]          HTRANS;
    logic [PA_BITS-1:0]  HADDR;
    logic                HWRITE;
    logic [2:0]          HSIZE;
    logic [XLEN-1:0]     HWDATA;
    logic [XLEN/8-1:0]   HWSTRB;
    logic                HREADY;
    logic                HRESP;
    logic [XLEN-1:0]     HRDATA;

    modport master (
        output HTRANS, HADDR, HWRITE, HSIZE, HWDATA, HWSTRB,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        input  HTRANS, HADDR, HWRITE, HSIZE, HWDATA, HWSTRB,
        output HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/ram_ahb_arbiter.sv
// Two-manager AHB-Lite arbiter sharing the single-ported on-chip RAM.
// Round-robin grant, SEQ/BUSY burst lock bounded by MAXBEATS contended beats.
module ram_ahb_arbiter #(
    parameter int unsigned PA_BITS  = 32,
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MAXBEATS = 16
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    ram_ahb_arbiter_if.slave    m0,
    ram_ahb_arbiter_if.slave    m1,
    output logic                HSELRam,
    output logic [PA_BITS-1:0]  HADDR,
    output logic                HWRITE,
    output logic [1:0]          HTRANS,
    output logic [2:0]          HSIZE,
    output logic [XLEN-1:0]     HWDATA,
    output logic [XLEN/8-1:0]   HWSTRB,
    output logic                HREADY,
    input  logic [XLEN-1:0]     HREADRam,
    input  logic                HREADYRam,
    input  logic                HRESPRam
);
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    localparam int unsigned CW = (MAXBEATS > 1) ? $clog2(MAXBEATS) : 1;

    logic          LastGrant;
    logic          DataValid;
    logic          DataOwner;
    logic          Lock;
    logic          LockOwner;
    logic [CW-1:0] BeatCnt;

    logic          req0, req1;
    logic          lock_act;
    logic          gnt;
    logic [1:0]    htrans_g;
    logic          req_g;
    logic          other_req;
    logic          busy_g;
    logic [CW-1:0] cnt_eff;
    logic          fair_cut;

    assign req0 = m0.HTRANS[1];
    assign req1 = m1.HTRANS[1];

    // The lock only binds while its owner continues the burst (SEQ or BUSY);
    // a fresh NONSEQ or IDLE from the owner goes back to round-robin.
    assign lock_act = Lock & (LockOwner ? m1.HTRANS[0] : m0.HTRANS[0]);

    always_comb begin
        gnt = LastGrant;
        if (lock_act)
            gnt = LockOwner;
        else if (req0 ^ req1)
            gnt = req1;
        else if (req0 & req1)
            gnt = ~LastGrant;
    end

    assign htrans_g  = gnt ? m1.HTRANS : m0.HTRANS;
    assign req_g     = htrans_g[1];
    assign other_req = gnt ? req0 : req1;
    assign busy_g    = lock_act & (htrans_g == BUSY);

    assign HSELRam = req_g | busy_g;
    assign HTRANS  = HSELRam ? htrans_g : IDLE;
    assign HADDR   = gnt ? m1.HADDR  : m0.HADDR;
    assign HWRITE  = gnt ? m1.HWRITE : m0.HWRITE;
    assign HSIZE   = gnt ? m1.HSIZE  : m0.HSIZE;

    assign HWDATA  = DataOwner ? m1.HWDATA : m0.HWDATA;
    assign HWSTRB  = DataOwner ? m1.HWSTRB : m0.HWSTRB;
    assign HREADY  = HREADYRam;

    assign m0.HRDATA = HREADRam;
    assign m1.HRDATA = HREADRam;
    assign m0.HREADY = HREADYRam & ((DataValid & ~DataOwner) | ~gnt);
    assign m1.HREADY = HREADYRam & ((DataValid &  DataOwner) |  gnt);
    assign m0.HRESP  = HRESPRam & DataValid & ~DataOwner;
    assign m1.HRESP  = HRESPRam & DataValid &  DataOwner;

    // A new owner starts counting from zero; the beat that reaches
    // MAXBEATS-1 while contended is the last one under lock.
    assign cnt_eff  = lock_act ? BeatCnt : '0;
    assign fair_cut = other_req & (cnt_eff == CW'(MAXBEATS - 1));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            LastGrant <= 1'b1;
            DataValid <= 1'b0;
            DataOwner <= 1'b0;
            Lock      <= 1'b0;
            LockOwner <= 1'b0;
            BeatCnt   <= '0;
        end else if (HREADYRam) begin
            DataValid <= req_g;
            DataOwner <= gnt;
            if (req_g) begin
                LastGrant <= gnt;
                LockOwner <= gnt;
                if (fair_cut) begin
                    Lock    <= 1'b0;
                    BeatCnt <= '0;
                end else begin
                    Lock    <= 1'b1;
                    BeatCnt <= other_req ? cnt_eff + CW'(1) : '0;
                end
            end else if (busy_g) begin
                if (!other_req)
                    BeatCnt <= '0;
            end else begin
                Lock    <= 1'b0;
                BeatCnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ram_ahb_arbiter.sv
// Self-checking bench for ram_ahb_arbiter: directed scenarios plus random traffic
// against a cycle-level behavioural model of the arbitration rules.
module tb_ram_ahb_arbiter;
    localparam int unsigned MAXB = 4;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSELRam, HWRITE, HREADY;
    logic [31:0] HADDR, HWDATA, HREADRam;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HWSTRB;
    logic        HREADYRam, HRESPRam;

    always #5 HCLK = ~HCLK;

    ram_ahb_arbiter_if #(.PA_BITS(32), .XLEN(32)) m0_bus();
    ram_ahb_arbiter_if #(.PA_BITS(32), .XLEN(32)) m1_bus();

    ram_ahb_arbiter #(.PA_BITS(32), .XLEN(32), .MAXBEATS(MAXB)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .m0(m0_bus), .m1(m1_bus),
        .HSELRam(HSELRam), .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWDATA(HWDATA), .HWSTRB(HWSTRB), .HREADY(HREADY),
        .HREADRam(HREADRam), .HREADYRam(HREADYRam), .HRESPRam(HRESPRam)
    );

    // Small RAM stub: captures address phases, writes in the data phase.
    logic [31:0] mem [256];
    logic        pend_v, pend_w;
    logic [31:0] pend_a;
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_v <= 1'b0;
            pend_w <= 1'b0;
            pend_a <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (HREADYRam) begin
            if (pend_v && pend_w) mem[pend_a[9:2]] <= HWDATA;
            pend_v <= HSELRam & HTRANS[1];
            pend_w <= HWRITE;
            pend_a <= HADDR;
        end
    end
    assign HREADRam = pend_v ? mem[pend_a[9:2]] : 32'h0;

    // Order in which the RAM accepted address phases.
    logic [31:0] acc_q [$];
    always @(posedge HCLK)
        if (HRESETn && HREADYRam && HSELRam && HTRANS[1]) acc_q.push_back(HADDR);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: who won last, who owns the data phase, who holds a burst.
    int last_w, d_owner, holder, run;
    bit d_valid;

    task automatic model_reset();
        last_w = 1; d_owner = 0; d_valid = 0; holder = -1; run = 0;
    endtask

    // Check all outputs for the current inputs, then advance one clock.
    task automatic cycle();
        logic [1:0]  t [2];
        logic [31:0] ad [2];
        logic [31:0] wd [2];
        logic        wr [2];
        logic [2:0]  sz [2];
        logic [3:0]  st [2];
        bit          want [2];
        bit          hold_act, sel;
        int          w, o, r;
        if (!HRESETn) model_reset();
        #1;
        t[0] = m0_bus.HTRANS; ad[0] = m0_bus.HADDR; wd[0] = m0_bus.HWDATA;
        wr[0] = m0_bus.HWRITE; sz[0] = m0_bus.HSIZE; st[0] = m0_bus.HWSTRB;
        t[1] = m1_bus.HTRANS; ad[1] = m1_bus.HADDR; wd[1] = m1_bus.HWDATA;
        wr[1] = m1_bus.HWRITE; sz[1] = m1_bus.HSIZE; st[1] = m1_bus.HWSTRB;
        for (int i = 0; i < 2; i++) want[i] = (t[i] == 2'b10) || (t[i] == 2'b11);
        hold_act = (holder >= 0) && (t[holder] == 2'b11 || t[holder] == 2'b01);
        if (hold_act)                w = holder;
        else if (want[0] && want[1]) w = 1 - last_w;
        else if (want[0])            w = 0;
        else if (want[1])            w = 1;
        else                         w = last_w;
        o = 1 - w;
        sel = want[w] || (hold_act && t[w] == 2'b01);

        check("ctl", {25'd0, sel, sel ? t[w] : 2'b00, wr[w], sz[w], ad[w]},
                     {25'd0, HSELRam, HTRANS, HWRITE, HSIZE, HADDR});
        check("wdat", {28'd0, HWSTRB, HWDATA}, {28'd0, st[d_owner], wd[d_owner]});
        check("rdy", {61'd0, m0_bus.HREADY, m1_bus.HREADY, HREADY},
                     {61'd0, HREADYRam && ((d_valid && d_owner == 0) || w == 0),
                             HREADYRam && ((d_valid && d_owner == 1) || w == 1), HREADYRam});
        check("resp", {62'd0, m0_bus.HRESP, m1_bus.HRESP},
                      {62'd0, HRESPRam && d_valid && d_owner == 0,
                              HRESPRam && d_valid && d_owner == 1});
        check("rdata", {m0_bus.HRDATA, m1_bus.HRDATA}, {HREADRam, HREADRam});

        @(posedge HCLK);
        if (HRESETn && HREADYRam) begin
            if (want[w]) begin
                last_w = w;
                r = hold_act ? run : 0;
                if (!want[o])           begin holder = w;  run = 0;     end
                else if (r + 1 >= MAXB) begin holder = -1; run = 0;     end
                else                    begin holder = w;  run = r + 1; end
            end else if (sel) begin
                if (!want[o]) run = 0;
            end else begin
                holder = -1; run = 0;
            end
            d_valid = want[w];
            d_owner = w;
        end
        @(negedge HCLK);
    endtask

    task automatic drive(input int m, input logic [1:0] tr, input logic [31:0] a,
                         input logic wr, input logic [31:0] wd);
        if (m == 0) begin
            m0_bus.HTRANS = tr; m0_bus.HADDR = a; m0_bus.HWRITE = wr;
            m0_bus.HSIZE = 3'd2; m0_bus.HWSTRB = 4'hF; m0_bus.HWDATA = wd;
        end else begin
            m1_bus.HTRANS = tr; m1_bus.HADDR = a; m1_bus.HWRITE = wr;
            m1_bus.HSIZE = 3'd2; m1_bus.HWSTRB = 4'hF; m1_bus.HWDATA = wd;
        end
    endtask

    // Simple managers: each holds its address until the RAM accepts it.
    int          m_left [2];
    int          m_idx  [2];
    logic [31:0] m_base [2];
    bit          m_burst[2];

    function automatic logic [31:0] m_addr(input int i);
        return m_base[i] + 32'(4 * m_idx[i]);
    endfunction

    task automatic run_mgrs(input int budget, input int stop1);
        int n;
        bit done;
        logic [31:0] last;
        done = 0;
        for (int c = 0; c < budget; c++) begin
            if ((m_left[0] == 0 && m_left[1] == 0) || (stop1 > 0 && m_idx[1] >= stop1)) begin
                done = 1;
                break;
            end
            for (int i = 0; i < 2; i++) begin
                if (m_left[i] > 0)
                    drive(i, (m_burst[i] && m_idx[i] > 0) ? 2'b11 : 2'b10, m_addr(i), 1'b0, $urandom);
                else
                    drive(i, 2'b00, m_base[i], 1'b0, $urandom);
            end
            n = acc_q.size();
            cycle();
            if (acc_q.size() > n) begin
                last = acc_q[$];
                for (int i = 0; i < 2; i++)
                    if (m_left[i] > 0 && last == m_addr(i)) begin
                        m_idx[i]++;
                        m_left[i]--;
                    end
            end
        end
        if (!done) check("mgr_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s, pos, k;
        logic [31:0] e;
        model_reset();
        HRESETn = 1'b0; HREADYRam = 1'b1; HRESPRam = 1'b1;
        drive(0, 2'b10, 32'h8000_0010, 1'b0, 32'h0);
        drive(1, 2'b10, 32'h9000_0010, 1'b0, 32'h0);
        @(negedge HCLK);
        #1;
        check("rst_rdy",  {62'd0, m0_bus.HREADY, m1_bus.HREADY}, 64'b10);
        check("rst_resp", {62'd0, m0_bus.HRESP, m1_bus.HRESP}, 64'b00);
        check("rst_sel",  {63'd0, HSELRam}, 64'd1);
        cycle();

        // Uncontended write then read-back by M0.
        HRESETn = 1'b1; HRESPRam = 1'b0;
        drive(0, 2'b10, 32'h8000_0000, 1'b1, 32'h0);
        drive(1, 2'b00, 32'h9000_0000, 1'b0, 32'h0);
        #1 check("wr_addr", {30'd0, HSELRam, HTRANS, HADDR}, {30'd0, 1'b1, 2'b10, 32'h8000_0000});
        cycle();
        drive(0, 2'b00, 32'h8000_0000, 1'b0, 32'hDEAD_BEEF);
        #1 check("wr_data", {32'd0, HWDATA}, {32'd0, 32'hDEAD_BEEF});
        cycle();
        drive(0, 2'b10, 32'h8000_0000, 1'b0, 32'h0);
        cycle();
        drive(0, 2'b00, 32'h8000_0000, 1'b0, 32'h0);
        #1 check("rd_data", {32'd0, m0_bus.HRDATA}, {32'd0, 32'hDEAD_BEEF});
        check("rd_resp", {63'd0, m0_bus.HRESP}, 64'd0);
        cycle();

        // Both managers issue single beats continuously: strict alternation.
        m_left = '{4, 4}; m_idx = '{0, 0}; m_burst = '{0, 0};
        m_base = '{32'h8000_0100, 32'h9000_0100};
        s = acc_q.size();
        run_mgrs(40, 0);
        check("alt_cnt", 64'(acc_q.size() - s), 64'd8);
        for (int j = 0; j < 8 && s + j < acc_q.size(); j++) begin
            e = ((j % 2) == 0) ? 32'h9000_0100 : 32'h8000_0100;
            check("alt_seq", {32'd0, acc_q[s + j]}, {32'd0, e + 32'(4 * (j / 2))});
        end

        // M1 16-beat burst against an M0 single: M0 gets in after MAXB beats.
        m_left = '{1, 16}; m_idx = '{0, 0}; m_burst = '{0, 1};
        m_base = '{32'h8000_0200, 32'h9000_0000};
        s = acc_q.size();
        run_mgrs(60, 0);
        check("fair_cnt", 64'(acc_q.size() - s), 64'd17);
        pos = -1; k = 0;
        for (int j = s; j < acc_q.size(); j++) begin
            if (acc_q[j] == 32'h8000_0200) pos = j - s;
            else begin
                check("burst_ord", {32'd0, acc_q[j]}, {32'd0, 32'h9000_0000 + 32'(4 * k)});
                k++;
            end
        end
        check("fair_pos", 64'(pos), 64'(MAXB));

        // RAM wait while M1 owns the data phase and M0 holds the grant.
        drive(0, 2'b00, 32'h8000_0300, 1'b0, 32'h0);
        drive(1, 2'b10, 32'h9000_0100, 1'b0, 32'h0);
        cycle();
        drive(0, 2'b10, 32'h8000_0300, 1'b0, 32'h0);
        drive(1, 2'b00, 32'h9000_0100, 1'b0, 32'h0);
        HREADYRam = 1'b0;
        #1 check("wait_rdy", {62'd0, m0_bus.HREADY, m1_bus.HREADY}, 64'b00);
        check("wait_addr", {30'd0, HTRANS, HADDR}, {30'd0, 2'b10, 32'h8000_0300});
        cycle();
        HREADYRam = 1'b1;
        #1 check("go_rdy", {62'd0, m0_bus.HREADY, m1_bus.HREADY}, 64'b11);
        check("go_addr", {30'd0, HTRANS, HADDR}, {30'd0, 2'b10, 32'h8000_0300});
        cycle();
        drive(0, 2'b00, 32'h8000_0300, 1'b0, 32'h0);
        cycle();

        // Asynchronous reset in the middle of an M1 burst.
        m_left = '{0, 16}; m_idx = '{0, 0}; m_burst = '{0, 1};
        m_base = '{32'h8000_0400, 32'h9000_0400};
        run_mgrs(20, 3);
        drive(0, 2'b10, 32'h8000_0400, 1'b0, 32'h0);
        drive(1, 2'b11, m_addr(1), 1'b0, 32'h0);
        HRESPRam = 1'b1;
        HRESETn = 1'b0;
        #1 check("arst_rdy", {62'd0, m0_bus.HREADY, m1_bus.HREADY}, 64'b10);
        check("arst_resp", {62'd0, m0_bus.HRESP, m1_bus.HRESP}, 64'b00);
        check("arst_addr", {32'd0, HADDR}, {32'd0, 32'h8000_0400});
        cycle();
        drive(1, 2'b10, 32'h9000_0800, 1'b0, 32'h0);
        HRESETn = 1'b1;
        #1 check("post_rst", {32'd0, HADDR}, {32'd0, 32'h8000_0400});
        cycle();

        // Random traffic, random RAM waits and responses.
        for (int c = 0; c < 500; c++) begin
            m0_bus.HTRANS = 2'($urandom_range(0, 3));
            m0_bus.HADDR  = 32'h8000_0000 | ($urandom & 32'h3FC);
            m0_bus.HWRITE = 1'($urandom);
            m0_bus.HSIZE  = 3'($urandom);
            m0_bus.HWSTRB = 4'($urandom);
            m0_bus.HWDATA = $urandom;
            m1_bus.HTRANS = 2'($urandom_range(0, 3));
            m1_bus.HADDR  = 32'h9000_0000 | ($urandom & 32'h3FC);
            m1_bus.HWRITE = 1'($urandom);
            m1_bus.HSIZE  = 3'($urandom);
            m1_bus.HWSTRB = 4'($urandom);
            m1_bus.HWDATA = $urandom;
            HREADYRam = ($urandom_range(0, 3) != 0);
            HRESPRam  = 1'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
